instr_fetch_unit: RTL and testbench

Producer side of the instruction interface consumed by the execute units (I_type et al.).
- Holds the PC and issues one-at-a-time word fetches to instruction memory over a req/rvalid handshake.
- Registers the returned word, then presents idata, iaddr and the sign-extended I-type immediate to execute under a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution.

---
 rtl/instr_fetch_unit_if.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between instr_fetch_unit, instruction memory and execute.
// With FETCH_PERF_EN defined the bundle also carries the perf counter outputs.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic [31:0] imm;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  modport master (
    output imem_req, imem_addr, instr_valid, idata, iaddr, imm, fetch_fault,
           perf_fetched, perf_stall,
    input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, idata, iaddr, imm, fetch_fault,
           perf_fetched, perf_stall,
    output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
`else
  modport master (
    output imem_req, imem_addr, instr_valid, idata, iaddr, imm, fetch_fault,
    input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, idata, iaddr, imm, fetch_fault,
    output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher: IDLE -> ISSUE <-> WAIT, HALT on misaligned redirect.
// FETCH_PERF_EN adds saturating accepted-instruction and stall-cycle counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_idata;
  logic [31:0] r_iaddr;
  logic        r_req;
  logic        r_valid;
  logic        r_fault;
  logic        r_drop;

  logic w_accept;
  logic w_slot_free;
  logic w_outstanding;
  logic w_misaligned;
  logic w_redirect;

  assign w_accept      = r_valid && bus.instr_ready;
  assign w_slot_free   = !r_valid || bus.instr_ready;
  assign w_outstanding = (r_state == S_WAIT) || r_drop;
  assign w_misaligned  = (bus.redirect_pc[1:0] != 2'b00);
  assign w_redirect    = bus.redirect && (r_state != S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= 32'h0;
      r_idata <= 32'h0;
      r_iaddr <= 32'h0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_req <= 1'b0;
      if (r_drop && bus.imem_rvalid)
        r_drop <= 1'b0;
      if (w_redirect) begin
        r_valid <= 1'b0;
        // A response arriving on the redirect edge is simply discarded; otherwise
        // the still-pending response must be swallowed when it returns.
        if (w_outstanding && !bus.imem_rvalid)
          r_drop <= 1'b1;
        if (w_misaligned) begin
          r_fault <= 1'b1;
          r_state <= S_HALT;
        end else begin
          r_pc    <= bus.redirect_pc;
          r_state <= S_ISSUE;
        end
      end else begin
        if (w_accept)
          r_valid <= 1'b0;
        case (r_state)
          S_IDLE: r_state <= S_ISSUE;
          S_ISSUE: begin
            if (w_slot_free && !r_drop) begin
              r_req   <= 1'b1;
              r_addr  <= r_pc;
              r_pc    <= r_pc + PC_STEP;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              r_valid <= 1'b1;
              r_idata <= bus.imem_rdata;
              r_iaddr <= r_addr;
              r_state <= S_ISSUE;
            end
          end
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = r_valid;
  assign bus.idata       = r_idata;
  assign bus.iaddr       = r_iaddr;
  assign bus.imm         = {{20{r_idata[31]}}, r_idata[31:20]};
  assign bus.fetch_fault = r_fault;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // An accept coinciding with a redirect is lost, so it is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= 32'h0;
      r_perf_stall   <= 32'h0;
    end else begin
      if (w_accept && !w_redirect && (r_perf_fetched != 32'hFFFF_FFFF))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (r_valid && !bus.instr_ready && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign bus.perf_fetched = r_perf_fetched;
  assign bus.perf_stall   = r_perf_stall;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall hold, redirect drop,
// misaligned fault, PC wrap and (with FETCH_PERF_EN) the perf counters.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus2();

  instr_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  // Memory: latency L puts rvalid L-1 cycles after the cycle imem_req is seen high.
  int          m_cnt;
  logic        m_busy;
  logic [31:0] m_addr;
  always @(negedge clk) begin
    bus.imem_rvalid = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
    end else begin
      if (bus.imem_req) begin
        m_busy = 1'b1;
        m_cnt  = mem_lat;
        m_addr = bus.imem_addr;
      end
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy          = 1'b0;
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = ovr_en ? ovr_val : m_addr + 32'h100;
        end
      end
    end
  end

  always @(negedge clk) begin
    bus2.imem_rvalid = bus2.imem_req && !reset;
    bus2.imem_rdata  = bus2.imem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.instr_ready = 1'b1; mem_lat = 1; ovr_en = 1'b0;
    do_reset();
    repeat (5) tick();
    reset = 1'b1;
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    n_tests++; if (bus.idata !== 32'h0) begin n_fail++; $display("FAIL reset_idata: got %h expected 0", bus.idata); end
    n_tests++; if (bus.iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h expected 0", bus.iaddr); end
    n_tests++; if (bus.imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm: got %h expected 0", bus.imm); end
    n_tests++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.fetch_fault); end
  endtask

  task automatic test_sequential();
    bit          exp_v, exp_r;
    logic [31:0] exp_a;
    bus.instr_ready = 1'b1; mem_lat = 1; ovr_en = 1'b0;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_v = (n >= 3) && (n % 2 == 1);
      exp_r = (n >= 2) && (n % 2 == 0);
      n_tests++; if (bus.instr_valid !== exp_v) begin n_fail++; $display("FAIL seq_valid edge %0d: got %b expected %b", n, bus.instr_valid, exp_v); end
      n_tests++; if (bus.imem_req !== exp_r) begin n_fail++; $display("FAIL seq_req edge %0d: got %b expected %b", n, bus.imem_req, exp_r); end
      if (exp_r) begin
        exp_a = 32'((n / 2 - 1) * 4);
        n_tests++; if (bus.imem_addr !== exp_a) begin n_fail++; $display("FAIL seq_addr edge %0d: got %h expected %h", n, bus.imem_addr, exp_a); end
      end
      if (exp_v) begin
        exp_a = 32'((n - 3) / 2 * 4);
        n_tests++; if (bus.iaddr !== exp_a) begin n_fail++; $display("FAIL seq_iaddr edge %0d: got %h expected %h", n, bus.iaddr, exp_a); end
        n_tests++; if (bus.idata !== exp_a + 32'h100) begin n_fail++; $display("FAIL seq_idata edge %0d: got %h expected %h", n, bus.idata, exp_a + 32'h100); end
      end
    end
  endtask

  task automatic test_stall();
    bus.instr_ready = 1'b0; mem_lat = 1; ovr_en = 1'b1; ovr_val = 32'hFFF0_0093;
    do_reset();
    repeat (3) tick();
    n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_first_valid: got %b expected 1", bus.instr_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req cycle %0d: got %b expected 0", i, bus.imem_req); end
      n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cycle %0d: got %b expected 1", i, bus.instr_valid); end
      n_tests++; if (bus.idata !== 32'hFFF0_0093) begin n_fail++; $display("FAIL stall_idata cycle %0d: got %h expected fff00093", i, bus.idata); end
      n_tests++; if (bus.iaddr !== 32'h0) begin n_fail++; $display("FAIL stall_iaddr cycle %0d: got %h expected 0", i, bus.iaddr); end
      n_tests++; if (bus.imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stall_imm cycle %0d: got %h expected ffffffff", i, bus.imm); end
    end
    ovr_val = 32'h1FF0_0093;
    bus.instr_ready = 1'b1;
    tick();
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b expected 0", bus.instr_valid); end
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_release_req: got %b expected 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_release_addr: got %h expected 4", bus.imem_addr); end
    bus.instr_ready = 1'b0;
    tick();
    n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL pos_imm_valid: got %b expected 1", bus.instr_valid); end
    n_tests++; if (bus.iaddr !== 32'h4) begin n_fail++; $display("FAIL pos_imm_iaddr: got %h expected 4", bus.iaddr); end
    n_tests++; if (bus.imm !== 32'h0000_01FF) begin n_fail++; $display("FAIL pos_imm: got %h expected 000001ff", bus.imm); end
    ovr_en = 1'b0;
  endtask

  task automatic test_redirect();
    bit found;
    bus.instr_ready = 1'b1; mem_lat = 4; ovr_en = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL redir_req8: got no request expected request to 00000008"); end
    repeat (2) tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b expected 0", bus.instr_valid); end
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_same: got %b expected 0", bus.imem_req); end
    tick();
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_drop_hold: got %b expected 0", bus.imem_req); end
    tick();
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req_new: got %b expected 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_addr_new: got %h expected 00000200", bus.imem_addr); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.instr_valid) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL redir_valid_timeout: got no instruction expected one"); end
    n_tests++; if (bus.iaddr !== 32'h200) begin n_fail++; $display("FAIL redir_iaddr: got %h expected 00000200", bus.iaddr); end
    n_tests++; if (bus.idata !== 32'h300) begin n_fail++; $display("FAIL redir_idata: got %h expected 00000300", bus.idata); end
  endtask

  task automatic test_fault();
    bus.instr_ready = 1'b0; mem_lat = 1; ovr_en = 1'b0;
    do_reset();
    repeat (3) tick();
    n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL fault_pre_valid: got %b expected 1", bus.instr_valid); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
    tick();
    bus.redirect = 1'b0;
    n_tests++; if (bus.fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_set: got %b expected 1", bus.fetch_fault); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fault_valid: got %b expected 0", bus.instr_valid); end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL fault_halt_req cycle %0d: got %b expected 0", i, bus.imem_req); end
      n_tests++; if (bus.fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky cycle %0d: got %b expected 1", i, bus.fetch_fault); end
    end
    reset = 1'b1;
    #1;
    n_tests++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b expected 0", bus.fetch_fault); end
    do_reset();
    repeat (2) tick();
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL fault_restart_req: got %b expected 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL fault_restart_addr: got %h expected 0", bus.imem_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] got [3];
    logic [31:0] exp [3];
    int          k;
    exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0000_0000;
    got[0] = 32'hDEAD_BEEF; got[1] = 32'hDEAD_BEEF; got[2] = 32'hDEAD_BEEF;
    k = 0;
    do_reset();
    for (int i = 0; i < 20 && k < 3; i++) begin
      tick();
      if (bus2.imem_req) begin
        got[k] = bus2.imem_addr;
        k++;
      end
    end
    n_tests++; if (k != 3) begin n_fail++; $display("FAIL wrap_count: got %0d requests expected 3", k); end
    for (int j = 0; j < 3; j++) begin
      n_tests++; if (got[j] !== exp[j]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h expected %h", j, got[j], exp[j]); end
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int acc, stl;
    acc = 0; stl = 0;
    bus.instr_ready = 1'b1; mem_lat = 1; ovr_en = 1'b0;
    do_reset();
    for (int i = 0; i < 100 && acc < 10; i++) begin
      if (bus.instr_valid) begin
        if (acc == 4 && stl < 3) begin bus.instr_ready = 1'b0; stl++; end
        else begin bus.instr_ready = 1'b1; acc++; end
      end else begin
        bus.instr_ready = 1'b1;
      end
      tick();
    end
    n_tests++; if (bus.perf_fetched !== 32'd10) begin n_fail++; $display("FAIL perf_fetched: got %0d expected 10", bus.perf_fetched); end
    n_tests++; if (bus.perf_stall !== 32'd3) begin n_fail++; $display("FAIL perf_stall: got %0d expected 3", bus.perf_stall); end
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    n_tests++; if (bus.perf_fetched !== 32'd0) begin n_fail++; $display("FAIL perf_fetched_reset: got %0d expected 0", bus.perf_fetched); end
    n_tests++; if (bus.perf_stall !== 32'd0) begin n_fail++; $display("FAIL perf_stall_reset: got %0d expected 0", bus.perf_stall); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instr_ready  = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus2.instr_ready = 1'b1;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
